dcp_bp_table: RTL and testbench

- Parametrised successor to the two-entry breakpoint command processor in the serial debug unit.
- When the debug controller selects the breakpoint command, the block receives one address over the RX handshake and toggles it in an NUM_BP-entry breakpoint table.
- It then prints every entry over the TX handshake, followed by CR and LF, and reports finish.
- It also compares the table against the CPU PC every cycle and raises a registered hit flag.

---
 rtl/dcp_pkg.sv | 31 +++
 rtl/dcp_bp_match.sv | 32 +++
 rtl/dcp_bp_table.sv | 266 ++++++++++++++++++++++++++
 tb/tb_dcp_bp_table.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcp_pkg.sv
// Shared definitions for the debug command processor blocks: FSM states,
// ASCII characters, command codes and TX type encodings.
package dcp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_UPDATE = 3'd2,
        ST_PRINT  = 3'd3,
        ST_CR     = 3'd4,
        ST_LF     = 3'd5,
        ST_DONE   = 3'd6
    } dcp_state_e;

    localparam logic [7:0] CHAR_CR = 8'h0d;
    localparam logic [7:0] CHAR_LF = 8'h0a;

    localparam logic [7:0] CMD_NONE = 8'h00;
    localparam logic [7:0] CMD_B    = 8'h42;
    localparam logic [7:0] CMD_R    = 8'h52;
    localparam logic [7:0] CMD_W    = 8'h57;

    localparam logic TYPE_HEX  = 1'b1;
    localparam logic TYPE_CHAR = 1'b0;

    // Width of an index into an n-entry table (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcp_bp_match.sv
// Comparator bank over the breakpoint table: per-entry match vector,
// lowest matching index, lowest free index and table-full flag for one key.
module dcp_bp_match
    import dcp_pkg::*;
#(
    parameter int AW     = 32,
    parameter int NUM_BP = 4,
    localparam int IW    = idx_width(NUM_BP)
) (
    input  logic [NUM_BP*AW-1:0] i_list,
    input  logic [NUM_BP-1:0]    i_valid,
    input  logic [AW-1:0]        i_key,
    output logic [NUM_BP-1:0]    o_match,
    output logic [IW-1:0]        o_first_match,
    output logic [IW-1:0]        o_first_free,
    output logic                 o_full
);

    // Walk from the top entry down so the lowest index wins both searches.
    always_comb begin
        o_match       = '0;
        o_first_match = '0;
        o_first_free  = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            o_match[i]    = i_valid[i] && (i_list[i*AW +: AW] == i_key);
            o_first_match = o_match[i] ? IW'(i) : o_first_match;
            o_first_free  = i_valid[i] ? o_first_free : IW'(i);
        end
        o_full = &i_valid;
    end

endmodule

// File: rtl/dcp_bp_table.sv
// Breakpoint command processor: toggles one received address in an NUM_BP-entry
// table, prints the table over TX, and flags PC hits. DCP_BP_CLEAR_ALL_EN makes an empty operand clear all entries.
module dcp_bp_table
    import dcp_pkg::*;
#(
    parameter int         NUM_BP = 4,
    parameter int         AW     = 32,
    parameter logic [7:0] CMD    = CMD_B
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           sel_mode,
    output logic                 finish,
    input  logic [31:0]          din_rx,
    input  logic                 flag_rx,
    input  logic                 ack_rx,
    output logic                 req_rx,
    output logic                 type_rx,
    input  logic                 ack_tx,
    output logic                 req_tx,
    output logic                 type_tx,
    output logic [31:0]          dout,
    input  logic [AW-1:0]        pc,
    output logic                 bp_hit,
    output logic [NUM_BP*AW-1:0] bp_list,
    output logic [NUM_BP-1:0]    bp_valid,
    output logic                 full_err
);

    localparam int            IW       = idx_width(NUM_BP);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BP - 1);

    dcp_state_e            r_state, w_state_nxt;
    logic [IW-1:0]         r_idx, w_idx_nxt;
    logic                  r_req_rx, w_req_rx_nxt;
    logic                  r_req_tx, w_req_tx_nxt;
    logic                  r_finish, w_finish_nxt;
    logic                  w_capture, w_update;
    logic                  w_sel, w_tx_done, w_tx_raise;
    logic [AW-1:0]         r_key;
    logic                  r_flag;
    logic [NUM_BP*AW-1:0]  r_list, w_list_nxt;
    logic [NUM_BP-1:0]     r_valid, w_valid_nxt;
    logic                  r_full_err, w_full_err_nxt;
    logic [31:0]           r_dout, w_dout_nxt;
    logic                  r_type_tx, w_type_tx_nxt;
    logic [AW-1:0]         w_word_nxt;
    logic                  r_bp_hit;
    logic [NUM_BP-1:0]     w_op_match, w_pc_match;
    logic [IW-1:0]         w_op_first_match, w_op_first_free;
    logic                  w_op_full;
    logic [IW-1:0]         w_pc_unused_first_match, w_pc_unused_first_free;
    logic                  w_pc_unused_full;

    assign w_sel      = (sel_mode == CMD);
    assign w_tx_done  = r_req_tx && ack_tx;
    assign w_tx_raise = !r_req_tx && !ack_tx;

    dcp_bp_match #(.AW(AW), .NUM_BP(NUM_BP)) u_op_match (
        .i_list        (r_list),
        .i_valid       (r_valid),
        .i_key         (r_key),
        .o_match       (w_op_match),
        .o_first_match (w_op_first_match),
        .o_first_free  (w_op_first_free),
        .o_full        (w_op_full)
    );

    dcp_bp_match #(.AW(AW), .NUM_BP(NUM_BP)) u_pc_match (
        .i_list        (r_list),
        .i_valid       (r_valid),
        .i_key         (pc),
        .o_match       (w_pc_match),
        .o_first_match (w_pc_unused_first_match),
        .o_first_free  (w_pc_unused_first_free),
        .o_full        (w_pc_unused_full)
    );

    // Command sequencing and request handshakes; deselect overrides every state.
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_req_rx_nxt = r_req_rx;
        w_req_tx_nxt = r_req_tx;
        w_finish_nxt = 1'b0;
        w_capture    = 1'b0;
        w_update     = 1'b0;
        if (!w_sel) begin
            w_state_nxt  = ST_IDLE;
            w_req_rx_nxt = 1'b0;
            w_req_tx_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_SCAN;
                end
                ST_SCAN: begin
                    if (r_req_rx && ack_rx) begin
                        w_capture    = 1'b1;
                        w_req_rx_nxt = 1'b0;
                        w_state_nxt  = ST_UPDATE;
                    end else begin
                        w_req_rx_nxt = r_req_rx | (!r_req_rx && !ack_rx);
                    end
                end
                ST_UPDATE: begin
                    w_update     = 1'b1;
                    w_idx_nxt    = '0;
                    w_req_tx_nxt = !ack_tx;
                    w_state_nxt  = ST_PRINT;
                end
                ST_PRINT: begin
                    if (w_tx_done) begin
                        w_req_tx_nxt = 1'b0;
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = ST_CR;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_req_tx_nxt = r_req_tx | w_tx_raise;
                    end
                end
                ST_CR: begin
                    if (w_tx_done) begin
                        w_req_tx_nxt = 1'b0;
                        w_state_nxt  = ST_LF;
                    end else begin
                        w_req_tx_nxt = r_req_tx | w_tx_raise;
                    end
                end
                ST_LF: begin
                    if (w_tx_done) begin
                        w_req_tx_nxt = 1'b0;
                        w_state_nxt  = ST_DONE;
                    end else begin
                        w_req_tx_nxt = r_req_tx | w_tx_raise;
                    end
                end
                ST_DONE: begin
                    w_finish_nxt = 1'b1;
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_req_rx_nxt = 1'b0;
                    w_req_tx_nxt = 1'b0;
                end
            endcase
        end
    end

    // Table toggle rule; invalid entries are stored as all-ones so bp_list is a plain register.
    always_comb begin
        w_list_nxt     = r_list;
        w_valid_nxt    = r_valid;
        w_full_err_nxt = 1'b0;
        if (w_update) begin
            if (r_flag) begin
`ifdef DCP_BP_CLEAR_ALL_EN
                w_valid_nxt = '0;
                w_list_nxt  = '1;
`else
                w_valid_nxt = r_valid;
`endif
            end else if (r_key == {AW{1'b1}}) begin
                w_valid_nxt = r_valid;
            end else if (|w_op_match) begin
                w_valid_nxt[w_op_first_match]                = 1'b0;
                w_list_nxt[int'(w_op_first_match)*AW +: AW]  = '1;
            end else if (!w_op_full) begin
                w_valid_nxt[w_op_first_free]                 = 1'b1;
                w_list_nxt[int'(w_op_first_free)*AW +: AW]   = r_key;
            end else begin
                w_full_err_nxt = 1'b1;
            end
        end else begin
            w_full_err_nxt = 1'b0;
        end
    end

    // TX word for the upcoming state, taken from the post-update table so the first word is current.
    always_comb begin
        w_word_nxt = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            w_word_nxt = (IW'(i) == w_idx_nxt) ? w_list_nxt[i*AW +: AW] : w_word_nxt;
        end
        w_dout_nxt    = r_dout;
        w_type_tx_nxt = TYPE_HEX;
        case (w_state_nxt)
            ST_PRINT: begin
                w_dout_nxt            = '0;
                w_dout_nxt[AW-1:0]    = w_word_nxt;
                w_type_tx_nxt         = TYPE_HEX;
            end
            ST_CR: begin
                w_dout_nxt    = {24'h000000, CHAR_CR};
                w_type_tx_nxt = TYPE_CHAR;
            end
            ST_LF: begin
                w_dout_nxt    = {24'h000000, CHAR_LF};
                w_type_tx_nxt = TYPE_CHAR;
            end
            default: begin
                w_dout_nxt    = r_dout;
                w_type_tx_nxt = TYPE_HEX;
            end
        endcase
    end

    // State, handshake and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_req_rx   <= 1'b0;
            r_req_tx   <= 1'b0;
            r_finish   <= 1'b0;
            r_full_err <= 1'b0;
            r_dout     <= 32'h0000_0000;
            r_type_tx  <= TYPE_HEX;
            r_bp_hit   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_req_rx   <= w_req_rx_nxt;
            r_req_tx   <= w_req_tx_nxt;
            r_finish   <= w_finish_nxt;
            r_full_err <= w_full_err_nxt;
            r_dout     <= w_dout_nxt;
            r_type_tx  <= w_type_tx_nxt;
            r_bp_hit   <= |w_pc_match;
        end
    end

    // Operand capture and breakpoint table storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key   <= '0;
            r_flag  <= 1'b0;
            r_list  <= '1;
            r_valid <= '0;
        end else begin
            if (w_capture) begin
                r_key  <= din_rx[AW-1:0];
                r_flag <= flag_rx;
            end else begin
                r_key  <= r_key;
                r_flag <= r_flag;
            end
            r_list  <= w_list_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign finish   = r_finish;
    assign req_rx   = r_req_rx;
    assign type_rx  = TYPE_HEX;
    assign req_tx   = r_req_tx;
    assign type_tx  = r_type_tx;
    assign dout     = r_dout;
    assign bp_hit   = r_bp_hit;
    assign bp_list  = r_list;
    assign bp_valid = r_valid;
    assign full_err = r_full_err;

endmodule

// File: tb/tb_dcp_bp_table.sv
// Self-checking bench for dcp_bp_table: directed vector table, hand-written
// corner sequences and randomized commands against a behavioural table model.
module tb_dcp_bp_table;

    localparam int          NUM_BP = 4;
    localparam int          AW     = 32;
    localparam logic [7:0]  CMD    = 8'h42;
    localparam logic [31:0] FF     = 32'hFFFF_FFFF;

    logic                 clk;
    logic                 rst;
    logic [7:0]           sel_mode;
    logic                 finish;
    logic [31:0]          din_rx;
    logic                 flag_rx;
    logic                 ack_rx;
    logic                 req_rx;
    logic                 type_rx;
    logic                 ack_tx;
    logic                 req_tx;
    logic                 type_tx;
    logic [31:0]          dout;
    logic [AW-1:0]        pc;
    logic                 bp_hit;
    logic [NUM_BP*AW-1:0] bp_list;
    logic [NUM_BP-1:0]    bp_valid;
    logic                 full_err;

    dcp_bp_table #(.NUM_BP(NUM_BP), .AW(AW), .CMD(CMD)) dut (
        .clk(clk), .rst(rst), .sel_mode(sel_mode), .finish(finish),
        .din_rx(din_rx), .flag_rx(flag_rx), .ack_rx(ack_rx), .req_rx(req_rx),
        .type_rx(type_rx), .ack_tx(ack_tx), .req_tx(req_tx), .type_tx(type_tx),
        .dout(dout), .pc(pc), .bp_hit(bp_hit), .bp_list(bp_list),
        .bp_valid(bp_valid), .full_err(full_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int fe_base  = 0;

    always @(negedge clk) if (full_err === 1'b1) fe_cnt++;

    // Behavioural table: valid flag and stored address per entry.
    logic [31:0] m_ent [NUM_BP];
    logic        m_val [NUM_BP];

    typedef struct {
        logic [31:0]  addr;
        logic         flag;
        logic [3:0]   valid;
        logic [127:0] list;
        int           fe;
    } vec_t;
    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input int i);
        return m_val[i] ? m_ent[i] : FF;
    endfunction

    function automatic logic [127:0] m_list();
        logic [127:0] l;
        for (int i = 0; i < NUM_BP; i++) l[i*32 +: 32] = m_word(i);
        return l;
    endfunction

    function automatic logic [3:0] m_valid();
        logic [3:0] v;
        for (int i = 0; i < NUM_BP; i++) v[i] = m_val[i];
        return v;
    endfunction

    function automatic logic m_hit(input logic [31:0] p);
        for (int i = 0; i < NUM_BP; i++) if (m_val[i] && m_ent[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < NUM_BP; i++) begin
            m_val[i] = 1'b0;
            m_ent[i] = 32'h0;
        end
    endfunction

    // Applies the toggle rule; returns expected number of full_err pulses.
    function automatic int m_apply(input logic [31:0] a, input logic f);
        if (f) begin
`ifdef DCP_BP_CLEAR_ALL_EN
            for (int i = 0; i < NUM_BP; i++) m_val[i] = 1'b0;
`endif
            return 0;
        end
        if (a == FF) return 0;
        for (int i = 0; i < NUM_BP; i++)
            if (m_val[i] && m_ent[i] == a) begin
                m_val[i] = 1'b0;
                return 0;
            end
        for (int i = 0; i < NUM_BP; i++)
            if (!m_val[i]) begin
                m_val[i] = 1'b1;
                m_ent[i] = a;
                return 0;
            end
        return 1;
    endfunction

    task automatic send_addr(input logic [31:0] a, input logic f, output int exp_fe);
        for (int n = 0; n < 50 && !req_rx; n++) tick();
        chk_b("req_rx_up", req_rx, 1'b1);
        din_rx  = a;
        flag_rx = f;
        ack_rx  = 1'b1;
        fe_base = fe_cnt;
        tick();
        ack_rx = 1'b0;
        exp_fe = m_apply(a, f);
        chk_b("req_rx_drop", req_rx, 1'b0);
        tick();
        chk_b("rx2tx_latency", req_tx, 1'b1);
    endtask

    task automatic finish_tx(input int exp_fe, output int fe_seen);
        logic [31:0] ew;
        for (int w = 0; w < NUM_BP + 2; w++) begin
            for (int n = 0; n < 50 && !req_tx; n++) tick();
            chk_b("req_tx_up", req_tx, 1'b1);
            ew = (w < NUM_BP) ? m_word(w) : ((w == NUM_BP) ? 32'h0000_000d : 32'h0000_000a);
            chk_w("tx_word", 128'(dout), 128'(ew));
            chk_b("tx_type", type_tx, (w < NUM_BP) ? 1'b1 : 1'b0);
            repeat ($urandom_range(0, 2)) tick();
            ack_tx = 1'b1;
            tick();
            chk_b("req_tx_drop", req_tx, 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                tick();
                chk_b("req_tx_wait_ack_low", req_tx, 1'b0);
            end
            ack_tx = 1'b0;
        end
        for (int n = 0; n < 20 && !finish; n++) tick();
        chk_b("finish_set", finish, 1'b1);
        fe_seen = fe_cnt - fe_base;
        chk_w("full_err_pulses", 128'(fe_seen), 128'(exp_fe));
        chk_w("table_valid", 128'(bp_valid), 128'(m_valid()));
        chk_w("table_list", bp_list, m_list());
        sel_mode = 8'h00;
        tick();
        chk_b("finish_clear", finish, 1'b0);
    endtask

    task automatic do_cmd(input logic [31:0] a, input logic f, output int fe_seen);
        int exp_fe;
        sel_mode = CMD;
        send_addr(a, f, exp_fe);
        finish_tx(exp_fe, fe_seen);
    endtask

    initial begin
        int fe_seen;
        int dummy;
        logic [31:0] pool [6];
        logic [31:0] a;
        logic f;

        vecs[0] = '{32'h100,  1'b0, 4'b0001, {FF, FF, FF, 32'h100}, 0};
        vecs[1] = '{32'h200,  1'b0, 4'b0011, {FF, FF, 32'h200, 32'h100}, 0};
        vecs[2] = '{32'h100,  1'b0, 4'b0010, {FF, FF, 32'h200, FF}, 0};
        vecs[3] = '{32'h300,  1'b0, 4'b0011, {FF, FF, 32'h200, 32'h300}, 0};
        vecs[4] = '{32'h2000, 1'b0, 4'b0111, {FF, 32'h2000, 32'h200, 32'h300}, 0};
        vecs[5] = '{32'h400,  1'b0, 4'b1111, {32'h400, 32'h2000, 32'h200, 32'h300}, 0};
        vecs[6] = '{32'h500,  1'b0, 4'b1111, {32'h400, 32'h2000, 32'h200, 32'h300}, 1};
`ifdef DCP_BP_CLEAR_ALL_EN
        vecs[7] = '{32'h300,  1'b1, 4'b0000, {FF, FF, FF, FF}, 0};
        vecs[8] = '{FF,       1'b0, 4'b0000, {FF, FF, FF, FF}, 0};
`else
        vecs[7] = '{32'h300,  1'b1, 4'b1111, {32'h400, 32'h2000, 32'h200, 32'h300}, 0};
        vecs[8] = '{FF,       1'b0, 4'b1111, {32'h400, 32'h2000, 32'h200, 32'h300}, 0};
`endif
        pool = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600};

        rst = 1'b1; sel_mode = 8'h00; din_rx = 32'h0; flag_rx = 1'b0;
        ack_rx = 1'b0; ack_tx = 1'b0; pc = 32'h0;
        m_clear();
        tick();
        tick();
        chk_b("rst_finish", finish, 1'b0);
        chk_b("rst_req_rx", req_rx, 1'b0);
        chk_b("rst_req_tx", req_tx, 1'b0);
        chk_b("rst_full_err", full_err, 1'b0);
        chk_b("rst_bp_hit", bp_hit, 1'b0);
        chk_b("rst_type_tx", type_tx, 1'b1);
        chk_b("type_rx", type_rx, 1'b1);
        chk_w("rst_dout", 128'(dout), 128'(32'h0));
        chk_w("rst_valid", 128'(bp_valid), 128'(4'b0000));
        chk_w("rst_list", bp_list, {FF, FF, FF, FF});
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            do_cmd(vecs[v].addr, vecs[v].flag, fe_seen);
            chk_w("vec_valid", 128'(bp_valid), 128'(vecs[v].valid));
            chk_w("vec_list", bp_list, vecs[v].list);
            chk_w("vec_full_err", 128'(fe_seen), 128'(vecs[v].fe));
        end

        pc = 32'h2000;
        tick();
        chk_b("pc_hit", bp_hit, 1'b1);
        pc = 32'h2004;
        tick();
        chk_b("pc_miss", bp_hit, 1'b0);

        // Deselect while printing: table update sticks, handshake aborts.
        sel_mode = CMD;
        send_addr(32'h2000, 1'b0, dummy);
        sel_mode = 8'h00;
        tick();
        chk_b("drop_req_tx", req_tx, 1'b0);
        chk_b("drop_finish", finish, 1'b0);
        chk_w("drop_valid", 128'(bp_valid), 128'(4'b1011));
        tick();
        chk_b("drop_idle_req_rx", req_rx, 1'b0);
        do_cmd(32'h2000, 1'b0, fe_seen);

        for (int v = 7; v < 9; v++) begin
            do_cmd(vecs[v].addr, vecs[v].flag, fe_seen);
            chk_w("vec_valid", 128'(bp_valid), 128'(vecs[v].valid));
            chk_w("vec_list", bp_list, vecs[v].list);
            chk_w("vec_full_err", 128'(fe_seen), 128'(vecs[v].fe));
        end

        // Reset while waiting for the operand.
        do_cmd(32'h700, 1'b0, fe_seen);
        sel_mode = CMD;
        for (int n = 0; n < 50 && !req_rx; n++) tick();
        chk_b("scan_req_rx", req_rx, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_clear();
        chk_b("midrst_req_rx", req_rx, 1'b0);
        chk_w("midrst_valid", 128'(bp_valid), 128'(4'b0000));
        chk_w("midrst_list", bp_list, {FF, FF, FF, FF});
        sel_mode = 8'h00;
        tick();

        for (int r = 0; r < 25; r++) begin
            a = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) a = FF;
            f = ($urandom_range(0, 7) == 0);
            do_cmd(a, f, fe_seen);
            pc = ($urandom_range(0, 1) == 1) ? m_ent[$urandom_range(0, NUM_BP - 1)] : pool[$urandom_range(0, 5)];
            tick();
            chk_b("rand_bp_hit", bp_hit, m_hit(pc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
